mc_controller: RTL
==================

# mc_controller

Multi-cycle control FSM that drives the shared datapath of the processor's multi-cycle variant: one ALU, one unified instruction/data memory port, one register file. It fetches each instruction, decodes the 6-bit opcode and issues per-state Moore control signals. The register file, ALU, IR/MDR/ALUOut registers and PC live in the datapath. The controller waits on a variable-latency memory handshake and pulses a completion strobe when each instruction retires.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26]; sampled in DECODE only
- zero  in  1  ALU zero flag; used in BRANCH only
- mem_ready  in  1  memory completes the current access this cycle
- mem_read / mem_write  out  1  memory access request, held until mem_ready
- ior  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  load IR from memory data
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load when zero = 1
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target {PC[31:28], IR[25:0], 2'b00}, 11 register rs
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 register B, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm << 2
- alu_op  out  2  00 R-type funct, 01 add, 10 sub, 11 slt
- reg_write  out  1  register file write enable
- reg_dst  out  2  00 rt, 01 rd, 10 r31
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
- instr_done  out  1  one-cycle pulse in the last state of every instruction
- illegal_op  out  1  present only with MC_CTRL_ILLEGAL_TRAP_EN

## Operation
- Opcodes: 000000 R-type, 000001 lw, 000010 sw, 000011 addi, 000100 slti, 000101 j, 000110 jal, 000111 jr, 001000 beq.
- States: RST, FETCH, DECODE, EXEC_R, R_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_I, I_WB, BRANCH, JUMP, JAL, JR, plus TRAP with the macro.
- RST → FETCH unconditionally. RST drives every output to 0.
- FETCH: mem_read=1, ior=0, alu_src_a=0, alu_src_b=01, alu_op=01.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=00, then go to DECODE.
  - When mem_ready=0: ir_write=0, pc_write=0, stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=01 (branch target into ALUOut). Dispatch on opcode.
  - R-type → EXEC_R
  - lw/sw → MEM_ADDR
  - addi/slti → EXEC_I
  - beq → BRANCH
  - j → JUMP
  - jal → JAL
  - jr → JR
- EXEC_R: a=1, b=00, alu_op=00. Then R_WB: reg_write=1, reg_dst=01, mem_to_reg=00.
- MEM_ADDR: a=1, b=10, alu_op=01. Next state is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, ior=1. Held until mem_ready, then go to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01.
- MEM_WR: mem_write=1, ior=1. Held until mem_ready; retires in that cycle.
- EXEC_I: a=1, b=10, alu_op=01 for addi, 11 for slti. Then I_WB: reg_write=1, reg_dst=00, mem_to_reg=00.
- BRANCH: a=1, b=00, alu_op=10, pc_write_cond=1, pc_src=01.
- JUMP: pc_write=1, pc_src=10.
- JAL: pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10. PC here already holds PC+4.
- JR: pc_write=1, pc_src=11.
- Every terminal state (R_WB, MEM_WB, MEM_WR with mem_ready, I_WB, BRANCH, JUMP, JAL, JR) asserts instr_done and returns to FETCH.
- The opcode is latched into an internal register in DECODE. Later states use the latched copy, never the live input.
- Outputs not listed for a state are 0.

## Timing
- State register is asynchronously reset to RST. All outputs are combinational decodes of the state (Moore), except the FETCH/MEM_WR outputs qualified by mem_ready.
- Cycles per instruction with mem_ready tied to 1:
  - R-type, sw, addi, slti: 4
  - lw: 5
  - beq, j, jal, jr: 3
- Each memory wait cycle adds 1.
- mem_read/mem_write stay stable and asserted while mem_ready=0; they never drop mid-access.
- rst_n asserted mid-instruction: outputs go to 0 immediately (asynchronously), and no partial write completes. First FETCH occurs one cycle after rst_n deassertion.
- mem_ready high outside FETCH/MEM_RD/MEM_WR: ignored.

## Configuration
- MC_CTRL_ILLEGAL_TRAP_EN defined: an undefined opcode in DECODE → TRAP.
  - TRAP holds illegal_op=1 with all other outputs 0 until reset.
  - No instr_done is asserted in TRAP.
- MC_CTRL_ILLEGAL_TRAP_EN undefined: an undefined opcode is a NOP. DECODE asserts instr_done and returns to FETCH. The illegal_op port does not exist.

## Structure
- Package mc_ctrl_pkg holds:
  - opcode constants
  - the state enum
  - the alu_op, alu_src_b, pc_src, reg_dst and mem_to_reg encodings
- Sub-module mc_ctrl_outdec: combinational state (+ latched opcode, mem_ready) → control vector. The FSM next-state logic stays in mc_controller.

## Test plan
- Reset with mem_ready=1, opcode=000000 → all outputs 0 during reset; FETCH on the first edge after release; instr_done exactly on cycle 4; reg_dst=01 in R_WB.
- lw with mem_ready low 3 cycles in MEM_RD → mem_read held for 4 cycles with ior=1; MEM_WB then writes with mem_to_reg=01; total 8 cycles.
- beq with zero=1 and with zero=0 → pc_write_cond=1, pc_src=01 in cycle 3 in both cases; instr_done on cycle 3.
- jal → cycle 3 shows pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10.
- opcode 111111 → with the macro, illegal_op=1 stuck until rst_n; without it, instr_done in DECODE and FETCH next.
- rst_n pulsed low during MEM_WR with mem_ready=0 → mem_write drops asynchronously and instr_done never fires.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: opcodes, FSM states,
// datapath mux/ALU encodings and the control vector.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b000001;
    localparam logic [5:0] OP_SW    = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b000011;
    localparam logic [5:0] OP_SLTI  = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000101;
    localparam logic [5:0] OP_JAL   = 6'b000110;
    localparam logic [5:0] OP_JR    = 6'b000111;
    localparam logic [5:0] OP_BEQ   = 6'b001000;

    typedef enum logic [3:0] {
        ST_RST, ST_FETCH, ST_DECODE, ST_EXEC_R, ST_R_WB,
        ST_MEM_ADDR, ST_MEM_RD, ST_MEM_WB, ST_MEM_WR,
        ST_EXEC_I, ST_I_WB, ST_BRANCH, ST_JUMP, ST_JAL, ST_JR, ST_TRAP
    } state_t;

    typedef enum logic [1:0] {ALU_FUNCT = 2'b00, ALU_ADD = 2'b01, ALU_SUB = 2'b10, ALU_SLT = 2'b11} alu_op_t;
    typedef enum logic [1:0] {SRCB_B = 2'b00, SRCB_4 = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH = 2'b11} alu_src_b_t;
    typedef enum logic [1:0] {PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_JUMP = 2'b10, PC_RS = 2'b11} pc_src_t;
    typedef enum logic [1:0] {DST_RT = 2'b00, DST_RD = 2'b01, DST_R31 = 2'b10} reg_dst_t;
    typedef enum logic [1:0] {M2R_ALUOUT = 2'b00, M2R_MDR = 2'b01, M2R_PC = 2'b10} mem_to_reg_t;

    typedef struct packed {
        logic        mem_read;
        logic        mem_write;
        logic        ior;
        logic        ir_write;
        logic        pc_write;
        logic        pc_write_cond;
        pc_src_t     pc_src;
        logic        alu_src_a;
        alu_src_b_t  alu_src_b;
        alu_op_t     alu_op;
        logic        reg_write;
        reg_dst_t    reg_dst;
        mem_to_reg_t mem_to_reg;
        logic        instr_done;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        return op <= OP_BEQ;
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Unified memory port handshake between the controller and instruction/data memory.
interface mc_ctrl_if;
    logic mem_read;
    logic mem_write;
    logic ior;
    logic mem_ready;

    modport master (output mem_read, mem_write, ior, input mem_ready);
    modport slave  (input mem_read, mem_write, ior, output mem_ready);
endinterface

// File: rtl/mc_ctrl_outdec.sv
// Moore output decode: state (plus latched opcode and mem_ready) to control vector.
// illegal_op output exists only with MC_CTRL_ILLEGAL_TRAP_EN.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t      state,
    input  logic [5:0]  op_q,
    input  logic        mem_ready,
    input  logic        nop,
    output ctrl_t       ctrl
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    ,
    output logic        illegal_op
`endif
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_4;
                ctrl.alu_op    = ALU_ADD;
                if (mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    ctrl.pc_src   = PC_ALU;
                end
            end
            ST_DECODE: begin
                // Speculative branch target into ALUOut; undefined opcodes retire here as NOPs.
                ctrl.alu_src_b  = SRCB_IMM_SH;
                ctrl.alu_op     = ALU_ADD;
                ctrl.instr_done = nop;
            end
            ST_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
            end
            ST_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = DST_RD;
                ctrl.mem_to_reg = M2R_ALUOUT;
                ctrl.instr_done = 1'b1;
            end
            ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.ior      = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = DST_RT;
                ctrl.mem_to_reg = M2R_MDR;
                ctrl.instr_done = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.ior        = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            ST_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = (op_q == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            ST_I_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = DST_RT;
                ctrl.mem_to_reg = M2R_ALUOUT;
                ctrl.instr_done = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = PC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            ST_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_src     = PC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            ST_JAL: begin
                // PC already holds PC+4, which becomes the link value.
                ctrl.pc_write   = 1'b1;
                ctrl.pc_src     = PC_JUMP;
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = DST_R31;
                ctrl.mem_to_reg = M2R_PC;
                ctrl.instr_done = 1'b1;
            end
            ST_JR: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_src     = PC_RS;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign illegal_op = (state == ST_TRAP);
`endif

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle processor control FSM with variable-latency memory handshake.
// Optional MC_CTRL_ILLEGAL_TRAP_EN: undefined opcodes lock into TRAP until reset.
module mc_controller
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic        zero,
    mc_ctrl_if.master   mem,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic [1:0]  pc_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic        instr_done
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    ,
    output logic        illegal_op
`endif
);

    state_t     state;
    logic [5:0] op_q;
    logic       nop;
    ctrl_t      ctrl;

    // The branch condition is applied in the datapath through pc_write_cond.
    logic unused_zero;
    assign unused_zero = zero;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign nop = 1'b0;
`else
    assign nop = !op_legal(opcode);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RST;
            op_q  <= '0;
        end else begin
            case (state)
                ST_RST:   state <= ST_FETCH;
                ST_FETCH: if (mem.mem_ready) state <= ST_DECODE;
                ST_DECODE: begin
                    op_q <= opcode;
                    case (opcode)
                        OP_RTYPE:        state <= ST_EXEC_R;
                        OP_LW, OP_SW:    state <= ST_MEM_ADDR;
                        OP_ADDI, OP_SLTI: state <= ST_EXEC_I;
                        OP_BEQ:          state <= ST_BRANCH;
                        OP_J:            state <= ST_JUMP;
                        OP_JAL:          state <= ST_JAL;
                        OP_JR:           state <= ST_JR;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                        default:         state <= ST_TRAP;
`else
                        default:         state <= ST_FETCH;
`endif
                    endcase
                end
                ST_EXEC_R:   state <= ST_R_WB;
                ST_MEM_ADDR: state <= (op_q == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
                ST_MEM_RD:   if (mem.mem_ready) state <= ST_MEM_WB;
                ST_MEM_WR:   if (mem.mem_ready) state <= ST_FETCH;
                ST_EXEC_I:   state <= ST_I_WB;
                ST_TRAP:     state <= ST_TRAP;
                default:     state <= ST_FETCH;
            endcase
        end
    end

    mc_ctrl_outdec u_outdec (
        .state      (state),
        .op_q       (op_q),
        .mem_ready  (mem.mem_ready),
        .nop        (nop),
        .ctrl       (ctrl)
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        ,
        .illegal_op (illegal_op)
`endif
    );

    assign mem.mem_read  = ctrl.mem_read;
    assign mem.mem_write = ctrl.mem_write;
    assign mem.ior       = ctrl.ior;
    assign ir_write      = ctrl.ir_write;
    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign pc_src        = ctrl.pc_src;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign reg_write     = ctrl.reg_write;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign instr_done    = ctrl.instr_done;

endmodule
